// File: rtl/keygen_pkg.sv
// Shared definitions for the logistic-map keystream generator: default widths,
// reset constants, multiplier cycle count and the controller state encoding.
// Optional feature macro: KEYGEN_PERTURB_EN (adds the LFSR step helper).
package keygen_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 12;
    localparam int unsigned BURN_IN_DEFAULT    = 16;
    localparam int unsigned BURN_W             = 8;
    localparam int unsigned MUL_CYCLES         = 13;
    localparam int unsigned LFSR_W             = 8;

    localparam logic [11:0]       SEED_DEFAULT = 12'h555;
    localparam logic [11:0]       R_DEFAULT    = 12'hFF0;
    localparam logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        MUL_A,
        MUL_B,
        UPDATE,
        EMIT
    } keygen_state_t;

`ifdef KEYGEN_PERTURB_EN
    // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction
`endif

endpackage

// File: rtl/fxp_mul_seq.sv
// Sequential unsigned shift-add multiplier, one partial product per cycle.
// A start pulse consumes multiplier bit 0 on its own edge, so the product is
// complete B_W edges after start. done_c marks the final accumulate cycle.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          load operands and begin (ignored while clear is high)
//   clear          abort any multiply in progress
//   a [A_W]        multiplicand
//   b [B_W]        multiplier
//   product [P_W]  accumulated result, stable once busy drops
//   busy           multiply in progress
//   done_c         combinational: this cycle is the last accumulate step
module fxp_mul_seq
    import keygen_pkg::*;
#(
    parameter int unsigned A_W = DATA_WIDTH_DEFAULT,
    parameter int unsigned B_W = MUL_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic [A_W+B_W-1:0]   product,
    output logic                 busy,
    output logic                 done_c
);

    localparam int unsigned P_W = A_W + B_W;
    localparam int unsigned CW  = $clog2(B_W + 1);

    logic [P_W-1:0] mcand;
    logic [B_W-1:0] mplier;
    logic [CW-1:0]  cnt;

    // Shift-add datapath and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (clear) begin
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            product <= b[0] ? P_W'(a) : '0;
            mcand   <= P_W'(a) << 1;
            mplier  <= b >> 1;
            cnt     <= CW'(B_W - 1);
            busy    <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done_c = busy && (cnt == CW'(1));

endmodule

// File: rtl/logistic_keygen.sv
// Logistic-map keystream generator: x <- r*x*(1-x) in fixed point, x as
// unsigned Q0.12 and r as unsigned Q2.10. Both products share one sequential
// multiplier (13 cycles each), giving 27 cycles per iteration. After each seed
// load BURN_IN iterations are discarded before words are emitted.
// Optional macro KEYGEN_PERTURB_EN: an 8-bit LFSR stepped once per update
// perturbs bit 0 of each new x before the zero guard.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   seed_load       one-cycle pulse capturing seed and r_param
//   seed            initial x (0 is replaced by 12'h555)
//   r_param         logistic coefficient r
//   enable          permits new iterations to start
//   key_ready       downstream accept for key_out
//   key_out         current keystream word
//   key_valid       key_out holds a new word
//   busy            an iteration is in progress
module logistic_keygen
    import keygen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned BURN_IN    = BURN_IN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_load,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] r_param,
    input  logic                  enable,
    input  logic                  key_ready,
    output logic [DATA_WIDTH-1:0] key_out,
    output logic                  key_valid,
    output logic                  busy
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DW + 1;
    localparam int unsigned RFRAC = DW - 2;
    localparam int unsigned SW    = PW - RFRAC;

    keygen_state_t     state;
    logic [DW-1:0]     x;
    logic [DW-1:0]     r;
    logic [BURN_W-1:0] burn;

    logic [DW:0]       x_comp;
    logic [DW-1:0]     mul_a;
    logic [DW:0]       mul_b;
    logic [PW-1:0]     mul_p;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done_c;

    logic [SW-1:0]     scaled;
    logic [DW-1:0]     sat;
    logic [DW-1:0]     x_next;
    logic              unused_bits;

    // 1.0 - x in Q0.12 needs one extra bit (x is never 0, so it stays <= 4095).
    assign x_comp = {1'b1, {DW{1'b0}}} - {1'b0, x};

    // First pass forms a = x*(1-x); second pass forms r*(a>>12).
    assign mul_a     = (state == MUL_A) ? x : r;
    assign mul_b     = (state == MUL_A) ? x_comp : mul_p[PW-1:DW];
    assign mul_start = ((state == MUL_A) || (state == MUL_B)) && !mul_busy;

    fxp_mul_seq #(
        .A_W (DW),
        .B_W (DW + 1)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .clear   (seed_load),
        .a       (mul_a),
        .b       (mul_b),
        .product (mul_p),
        .busy    (mul_busy),
        .done_c  (mul_done_c)
    );

`ifdef KEYGEN_PERTURB_EN
    logic [LFSR_W-1:0] lfsr;

    // Perturbation LFSR: restarts with each seed, steps once per update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (seed_load) begin
            lfsr <= LFSR_SEED;
        end else if (state == UPDATE) begin
            lfsr <= lfsr_step(lfsr);
        end
    end
`endif

    assign scaled      = mul_p[PW-1:RFRAC];
    assign unused_bits = ^mul_p[RFRAC-1:0];

    // Rescale r*b from Q2.10, saturate, optionally perturb, then guard zero.
    always_comb begin
        sat    = '0;
        x_next = '0;
        sat    = (|scaled[SW-1:DW]) ? '1 : scaled[DW-1:0];
`ifdef KEYGEN_PERTURB_EN
        sat[0] = sat[0] ^ lfsr[0];
`endif
        x_next = (sat == '0) ? DW'(1) : sat;
    end

    // Iteration controller; seed_load overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= DW'(SEED_DEFAULT);
            r         <= DW'(R_DEFAULT);
            burn      <= BURN_W'(BURN_IN);
            key_out   <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (seed_load) begin
            x         <= (seed == '0) ? DW'(SEED_DEFAULT) : seed;
            r         <= r_param;
            burn      <= BURN_W'(BURN_IN);
            key_valid <= 1'b0;
            state     <= enable ? MUL_A : IDLE;
            busy      <= enable;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= MUL_A;
                        busy  <= 1'b1;
                    end
                end
                MUL_A: begin
                    if (mul_done_c) begin
                        state <= MUL_B;
                    end
                end
                MUL_B: begin
                    if (mul_done_c) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    x <= x_next;
                    if (burn != '0) begin
                        burn  <= burn - BURN_W'(1);
                        state <= enable ? MUL_A : IDLE;
                        busy  <= enable;
                    end else begin
                        key_out   <= x_next;
                        key_valid <= 1'b1;
                        state     <= EMIT;
                        busy      <= 1'b0;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        state     <= enable ? MUL_A : IDLE;
                        busy      <= enable;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logistic_keygen.sv
// Directed bench for logistic_keygen: two instances share stimulus, one with
// BURN_IN=0 (every iteration emitted) and one with BURN_IN=2.
module tb_logistic_keygen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic        enable;
    logic        key_ready;
    logic [11:0] seed;
    logic [11:0] r_param;

    logic [11:0] key0, key2;
    logic        kv0, kv2, busy0, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logistic_keygen #(.DATA_WIDTH(12), .BURN_IN(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .r_param   (r_param),
        .enable    (enable),
        .key_ready (key_ready),
        .key_out   (key0),
        .key_valid (kv0),
        .busy      (busy0)
    );

    logistic_keygen #(.DATA_WIDTH(12), .BURN_IN(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .r_param   (r_param),
        .enable    (enable),
        .key_ready (key_ready),
        .key_out   (key2),
        .key_valid (kv2),
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until each instance first shows key_valid (0 = not seen).
    task automatic run_until(input int limit, output int n0, output int n2,
                             output logic [11:0] k0, output logic [11:0] k2);
        n0 = 0; n2 = 0; k0 = '0; k2 = '0;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (n0 == 0 && kv0) begin n0 = i; k0 = key0; end
            if (n2 == 0 && kv2) begin n2 = i; k2 = key2; end
            if (n0 != 0 && n2 != 0) break;
        end
    endtask

    task automatic load(input logic [11:0] s, input logic [11:0] rp);
        seed      = s;
        r_param   = rp;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
    endtask

    task automatic accept();
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0, n2, changes;
        logic [11:0] k0, k2, h0, h2;

        rst_n = 1'b0; seed_load = 1'b0; enable = 1'b0; key_ready = 1'b0;
        seed = '0; r_param = '0;
        repeat (3) step();
        check("rst_key_out", key0, 0);
        check("rst_key_valid", kv0, 0);
        check("rst_busy", busy0, 0);
        check("rst_key_valid_b", kv2, 0);

        rst_n = 1'b1;
        repeat (5) step();
        check("idle_no_enable_busy", busy0, 0);
        check("idle_no_enable_valid", kv0, 0);

        // Default x=0x555, r=0xFF0: 3625, 1657, 3928.
        enable = 1'b1;
        step();
        run_until(200, n0, n2, k0, k2);
        check("dflt_lat", n0, 27);
        check("dflt_key", k0, 3625);
        check("dflt_lat_b", n2, 81);
        check("dflt_key_b", k2, 3928);
        check("emit_busy", busy0, 0);
        check("emit_valid", kv0, 1);

        // seed 1024, r 2048: 1536, 1920, 2040, 2046.
        load(12'd1024, 12'd2048);
        check("load_drop_valid", kv0, 0);
        check("load_drop_valid_b", kv2, 0);
        check("load_busy", busy0, 1);
        run_until(200, n0, n2, k0, k2);
        check("s1024_lat", n0, 27);
        check("s1024_key", k0, 1536);
        check("s1024_lat_b", n2, 81);
        check("s1024_key_b", k2, 2040);

        accept();
        check("accept_valid", kv0, 0);
        check("accept_busy", busy0, 1);
        run_until(200, n0, n2, k0, k2);
        check("next_lat", n0, 27);
        check("next_key", k0, 1920);
        check("next_lat_b", n2, 27);
        check("next_key_b", k2, 2046);

        // Fixed point at x=0.5, r=2.0.
        load(12'd2048, 12'd2048);
        run_until(200, n0, n2, k0, k2);
        check("half_lat", n0, 27);
        check("half_key", k0, 2048);
        check("half_key_b", k2, 2048);

        // Saturation to 4095, then zero guard on x=4095.
        load(12'd2048, 12'd4095);
        run_until(200, n0, n2, k0, k2);
        check("sat_key", k0, 4095);
        check("sat_guard_key_b", k2, 1);
        accept();
        run_until(200, n0, n2, k0, k2);
        check("guard_lat", n0, 27);
        check("guard_key", k0, 1);
        check("guard_key_b", k2, 1);

        // Zero seed replaced by 0x555: 1820, 2022, 2046.
        load(12'd0, 12'd2048);
        run_until(200, n0, n2, k0, k2);
        check("zseed_key", k0, 1820);
        check("zseed_key_b", k2, 2046);

        // Backpressure: words held while key_ready=0.
        h0 = key0; h2 = key2; changes = 0;
        repeat (50) begin
            step();
            if (key0 !== h0 || kv0 !== 1'b1 || busy0 !== 1'b0) changes++;
            if (key2 !== h2 || kv2 !== 1'b1 || busy2 !== 1'b0) changes++;
        end
        check("hold_stable", changes, 0);
        check("hold_valid", kv0, 1);
        check("hold_busy", busy0, 0);
        load(12'd1024, 12'd2048);
        check("hold_load_valid", kv0, 0);
        check("hold_load_valid_b", kv2, 0);
        run_until(200, n0, n2, k0, k2);
        check("reburn_lat", n0, 27);
        check("reburn_lat_b", n2, 81);
        check("reburn_key_b", k2, 2040);

        // Reset in the middle of the second multiply.
        load(12'd1024, 12'd2048);
        repeat (17) step();
        check("mid_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("async_key_out", key0, 0);
        check("async_valid", kv0, 0);
        check("async_busy", busy0, 0);
        check("async_busy_b", busy2, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_until(200, n0, n2, k0, k2);
        check("post_rst_lat", n0, 27);
        check("post_rst_key", k0, 3625);
        check("post_rst_lat_b", n2, 81);
        check("post_rst_key_b", k2, 3928);

        // enable dropped mid-iteration: iteration completes and is emitted.
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        enable    = 1'b0;
        run_until(200, n0, n2, k0, k2);
        check("dis_lat", n0, 27);
        check("dis_key", k0, 1657);
        check("dis_key_b", k2, 641);
        accept();
        repeat (5) step();
        check("dis_idle_busy", busy0, 0);
        check("dis_idle_valid", kv0, 0);
        check("dis_idle_busy_b", busy2, 0);

        // enable dropped during burn-in: no word, burn-in resumes later.
        enable = 1'b1;
        load(12'd1024, 12'd2048);
        enable = 1'b0;
        run_until(60, n0, n2, k0, k2);
        check("burn_stop_key", k0, 1536);
        check("burn_stop_valid_b", n2, 0);
        check("burn_stop_busy_b", busy2, 0);
        enable = 1'b1;
        step();
        run_until(200, n0, n2, k0, k2);
        check("burn_resume_lat_b", n2, 54);
        check("burn_resume_key_b", k2, 2040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
